// File: rtl/burst_bank_arbiter.sv
// burst_bank_arbiter
// Round-robin arbiter over NUM_BANKS request queues. Each lock serves one bank
// for up to MAX_BURST requests, and a one-deep registered output stage carries
// the accepted request downstream.
//
// Handshake: a bank offers a request by holding valid[b] high with its fields
// stable. ready[b] is a combinational pop strobe, and the request transfers on
// any rising edge where valid[b] & ready[b]. The output stage presents a request
// while wr_en is high and holds it until a rising edge with out_ready high.
// When the output slot is free, ready follows valid of the locked bank in the
// same cycle, so one request per clock can flow end to end.
//
// NUM_BANKS must equal 2**(BG_BITS+BA_BITS). The lock index then wraps modulo
// NUM_BANKS on its own.
module burst_bank_arbiter #(
    parameter int NUM_BANKS  = 16,
    parameter int BG_BITS    = 2,
    parameter int BA_BITS    = 2,
    parameter int INDEX_BITS = 7,
    parameter int RA_BITS    = 16,
    parameter int CA_BITS    = 10,
    parameter int DATA_BITS  = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_BANKS-1:0]                  valid,
    input  logic [NUM_BANKS-1:0][DATA_BITS-1:0]   data_i,
    input  logic [NUM_BANKS-1:0][INDEX_BITS-1:0]  idx_i,
    input  logic [NUM_BANKS-1:0][RA_BITS-1:0]     row_i,
    input  logic [NUM_BANKS-1:0][CA_BITS-1:0]     col_i,
    input  logic [NUM_BANKS-1:0]                  type_i,
    output logic [NUM_BANKS-1:0]                  ready,
    output logic [DATA_BITS-1:0]                  data_o,
    output logic [INDEX_BITS-1:0]                 idx_o,
    output logic [RA_BITS-1:0]                    row_o,
    output logic [CA_BITS-1:0]                    col_o,
    output logic                                  type_o,
    output logic [BA_BITS-1:0]                    ba_o,
    output logic [BG_BITS-1:0]                    bg_o,
    output logic                                  wr_en,
    input  logic                                  out_ready,
    output logic                                  dbg_state_o
);

    localparam int LOCK_W = BG_BITS + BA_BITS;
    localparam int CNT_W  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [LOCK_W-1:0]       lock_q, lock_d;
    logic [LOCK_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0]    data_q, data_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    logic [RA_BITS-1:0]      row_q, row_d;
    logic [CA_BITS-1:0]      col_q, col_d;
    logic                    type_q, type_d;
    logic [BA_BITS-1:0]      ba_q, ba_d;
    logic [BG_BITS-1:0]      bg_q, bg_d;
    logic                    wr_en_q, wr_en_d;

    logic [LOCK_W-1:0]       winner;
    logic                    slot_free;
    logic                    accept;
    logic                    last_burst;

    // Round-robin pick: first valid bank after the last served one, wrapping.
    always_comb begin
        logic [LOCK_W-1:0] cand;
        logic              found;
        winner = last_q;
        found  = 1'b0;
        cand   = last_q;
        for (int i = 1; i <= NUM_BANKS; i++) begin
            cand = last_q + LOCK_W'(i);
            if (!found && valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Next state, pop strobe and output-stage load/drain decisions.
    always_comb begin
        slot_free  = !wr_en_q || out_ready;
        accept     = (state_q == GRANT) && valid[lock_q] && slot_free;
        last_burst = (cnt_q == CNT_W'(MAX_BURST - 1));

        ready   = '0;
        state_d = state_q;
        lock_d  = lock_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        type_d  = type_q;
        ba_d    = ba_q;
        bg_d    = bg_q;
        wr_en_d = wr_en_q;

        if (accept) begin
            ready[lock_q] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|valid) begin
                    state_d = GRANT;
                    lock_d  = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A dropped valid ends the lock even while stalled; the cap
                // ends it on the accept that completes the burst.
                if (!valid[lock_q] || (accept && last_burst)) begin
                    state_d = IDLE;
                    last_d  = lock_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Loading a new request also retires the one being drained this cycle.
        if (accept) begin
            data_d  = data_i[lock_q];
            idx_d   = idx_i[lock_q];
            row_d   = row_i[lock_q];
            col_d   = col_i[lock_q];
            type_d  = type_i[lock_q];
            ba_d    = lock_q[BA_BITS-1:0];
            bg_d    = lock_q[LOCK_W-1:BA_BITS];
            wr_en_d = 1'b1;
        end else if (out_ready) begin
            wr_en_d = 1'b0;
        end
    end

    // State and output registers. Reset restarts priority at bank 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
            last_q  <= LOCK_W'(NUM_BANKS - 1);
            cnt_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            type_q  <= 1'b0;
            ba_q    <= '0;
            bg_q    <= '0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            type_q  <= type_d;
            ba_q    <= ba_d;
            bg_q    <= bg_d;
            wr_en_q <= wr_en_d;
        end
    end

    assign data_o      = data_q;
    assign idx_o       = idx_q;
    assign row_o       = row_q;
    assign col_o       = col_q;
    assign type_o      = type_q;
    assign ba_o        = ba_q;
    assign bg_o        = bg_q;
    assign wr_en       = wr_en_q;
    assign dbg_state_o = state_q;

endmodule
